// File: rtl/ucie_ctl_phy_sb_pkg.sv
// Shared types and defaults for the PHY sideband message RX path.
package ucie_ctl_phy_sb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        NO_CRD = 2'd2
    } sb_rx_states_e;

    localparam int SB_NC_DEF    = 32;
    localparam int SB_DEPTH_DEF = 4;

endpackage

// File: rtl/ucie_ctl_sb_sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty; head is read combinationally.
module ucie_ctl_sb_sync_fifo
    import ucie_ctl_phy_sb_pkg::*;
#(
    parameter int NC    = SB_NC_DEF,
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [NC-1:0] i_din,
    input  logic          i_pop,
    output logic [NC-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [NC-1:0] mem_q [DEPTH];
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en    = i_pop && !o_empty;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        wr_en    = i_push && (!o_full || rd_en);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_din;
        end
    end

    assign o_dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ucie_ctl_phy_sb_msg_interface_rx_dir.sv
// Sideband RX: buffers received words and forwards them to the Adapter on the
// RDI config channel under credit-based flow control.
module ucie_ctl_phy_sb_msg_interface_rx_dir
    import ucie_ctl_phy_sb_pkg::*;
#(
    parameter int NC       = SB_NC_DEF,
    parameter int DEPTH    = SB_DEPTH_DEF,
    parameter int CRD_INIT = 4,
    parameter int CRD_MAX  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sb_data_valid,
    input  logic [NC-1:0] i_sb_data,
    input  logic          i_lp_cfg_crd,
    output logic          o_pl_cfg_valid,
    output logic [NC-1:0] o_pl_cfg,
    output logic          o_sb_rx_overflow,
    output logic          o_crd_err,
    output logic          o_fifo_empty
);

    localparam int            CW         = $clog2(CRD_MAX + 1);
    localparam logic [CW-1:0] CRD_INIT_V = CW'(CRD_INIT);
    localparam logic [CW-1:0] CRD_MAX_V  = CW'(CRD_MAX);

    sb_rx_states_e state_q, state_d;
    logic [CW-1:0] crd_cnt_q, crd_cnt_d;
    logic          cfg_valid_q, cfg_valid_d;
    logic [NC-1:0] cfg_q, cfg_d;
    logic          ovf_q, ovf_d;
    logic          crd_err_q, crd_err_d;

    logic [NC-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    ucie_ctl_sb_sync_fifo #(
        .NC    (NC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_din   (i_sb_data),
        .i_pop   (pop),
        .o_dout  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // SEND is only ever held with a nonzero credit count, so this equals
    // "FIFO not empty and credit available".
    always_comb begin
        pop  = (state_q == SEND) && !fifo_empty;
        push = i_sb_data_valid && (!fifo_full || pop);
    end

    always_comb begin
        crd_cnt_d   = crd_cnt_q;
        crd_err_d   = crd_err_q;
        ovf_d       = ovf_q;
        cfg_valid_d = pop;
        cfg_d       = pop ? fifo_dout : '0;
        unique case ({pop, i_lp_cfg_crd})
            2'b10: crd_cnt_d = crd_cnt_q - CW'(1);
            2'b01: begin
                if (crd_cnt_q == CRD_MAX_V) begin
                    crd_err_d = 1'b1;
                end else begin
                    crd_cnt_d = crd_cnt_q + CW'(1);
                end
            end
            default: crd_cnt_d = crd_cnt_q;
        endcase
        if (i_sb_data_valid && !push) begin
            ovf_d = 1'b1;
        end
    end

    // Transitions look at the next credit count so SEND/NO_CRD always match
    // the registered counter in the following cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = (crd_cnt_d != '0) ? SEND : NO_CRD;
                end
            end
            SEND: begin
                if (fifo_empty && !push) begin
                    state_d = IDLE;
                end else if (crd_cnt_d == '0) begin
                    state_d = NO_CRD;
                end
            end
            NO_CRD: begin
                if (fifo_empty && !push) begin
                    state_d = IDLE;
                end else if (crd_cnt_d != '0) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            crd_cnt_q   <= CRD_INIT_V;
            cfg_valid_q <= 1'b0;
            cfg_q       <= '0;
            ovf_q       <= 1'b0;
            crd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crd_cnt_q   <= crd_cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_q       <= cfg_d;
            ovf_q       <= ovf_d;
            crd_err_q   <= crd_err_d;
        end
    end

    assign o_pl_cfg_valid   = cfg_valid_q;
    assign o_pl_cfg         = cfg_q;
    assign o_sb_rx_overflow = ovf_q;
    assign o_crd_err        = crd_err_q;
    assign o_fifo_empty     = fifo_empty;

endmodule

// File: tb/tb_ucie_ctl_phy_sb_msg_interface_rx_dir.sv
// Bench for the sideband RX interface: per-cycle vector table plus scoreboarded sequences.
module tb_ucie_ctl_phy_sb_msg_interface_rx_dir;

    localparam int NC       = 32;
    localparam int DEPTH    = 4;
    localparam int CRD_INIT = 4;
    localparam int CRD_MAX  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sb_v;
    logic [NC-1:0] sb_d;
    logic          crd;
    logic          o_pl_cfg_valid;
    logic [NC-1:0] o_pl_cfg;
    logic          o_sb_rx_overflow;
    logic          o_crd_err;
    logic          o_fifo_empty;

    int            tests = 0;
    int            fails = 0;
    int            delivered = 0;
    bit            sb_on = 1'b0;
    logic [31:0]   exp_q[$];

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    ucie_ctl_phy_sb_msg_interface_rx_dir #(
        .NC       (NC),
        .DEPTH    (DEPTH),
        .CRD_INIT (CRD_INIT),
        .CRD_MAX  (CRD_MAX)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_sb_data_valid  (sb_v),
        .i_sb_data        (sb_d),
        .i_lp_cfg_crd     (crd),
        .o_pl_cfg_valid   (o_pl_cfg_valid),
        .o_pl_cfg         (o_pl_cfg),
        .o_sb_rx_overflow (o_sb_rx_overflow),
        .o_crd_err        (o_crd_err),
        .o_fifo_empty     (o_fifo_empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and, when enabled, score any delivered word.
    task automatic step();
        @(posedge clk);
        #1;
        if (sb_on && o_pl_cfg_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(o_pl_cfg_valid), 32'd0);
            end else begin
                chk("sb_data", o_pl_cfg, exp_q.pop_front());
                delivered++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_word(input logic [31:0] d, input bit expect_out);
        sb_v = 1'b1;
        sb_d = d;
        if (expect_out) exp_q.push_back(d);
        step();
        sb_v = 1'b0;
        sb_d = '0;
    endtask

    task automatic crd_pulses(input int n);
        crd = 1'b1;
        idle(n);
        crd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        sb_v = 1'b0;
        sb_d = '0;
        crd  = 1'b0;
        idle(2);
        rst = 1'b0;

        chk("rst_valid", 32'(o_pl_cfg_valid), 32'd0);
        chk("rst_cfg", o_pl_cfg, 32'd0);
        chk("rst_empty", 32'(o_fifo_empty), 32'd1);
        chk("rst_ovf", 32'(o_sb_rx_overflow), 32'd0);
        chk("rst_crd_err", 32'(o_crd_err), 32'd0);
        chk("rst_cnt", 32'(dut.crd_cnt_q), 32'd4);

        // Single word latency, then a two-word back-to-back pair.
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{1'b1, 32'h0000_0022, 1'b0, 1'b1, 32'h0000_0011, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0022, 1'b1};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
        for (int i = 0; i < 9; i++) begin
            sb_v = vecs[i].v;
            sb_d = vecs[i].d;
            crd  = vecs[i].c;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(o_pl_cfg_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_cfg", i), o_pl_cfg, vecs[i].ed);
            chk($sformatf("vec%0d_empty", i), 32'(o_fifo_empty), 32'(vecs[i].ee));
        end
        sb_v = 1'b0;
        sb_d = '0;
        crd  = 1'b0;
        chk("vec_cnt_end", 32'(dut.crd_cnt_q), 32'd4);

        // Burst of 6 with 4 credits: 4 flow, 2 wait for returned credits.
        sb_on = 1'b1;
        delivered = 0;
        for (int i = 1; i <= 6; i++) push_word(32'(i), 1'b1);
        idle(4);
        chk("burst_delivered_4", 32'(delivered), 32'd4);
        chk("burst_pending", 32'(exp_q.size()), 32'd2);
        chk("burst_cnt0", 32'(dut.crd_cnt_q), 32'd0);
        chk("burst_valid_stall", 32'(o_pl_cfg_valid), 32'd0);
        crd_pulses(1);
        idle(2);
        crd_pulses(1);
        idle(3);
        chk("burst_delivered_6", 32'(delivered), 32'd6);
        chk("burst_no_ovf", 32'(o_sb_rx_overflow), 32'd0);

        // No credits: fill the FIFO, fifth word drops.
        delivered = 0;
        for (int i = 1; i <= 5; i++) push_word(32'h100 + 32'(i), i != 5);
        chk("ovf_set", 32'(o_sb_rx_overflow), 32'd1);
        chk("ovf_not_empty", 32'(o_fifo_empty), 32'd0);
        idle(3);
        chk("ovf_sticky", 32'(o_sb_rx_overflow), 32'd1);
        chk("ovf_none_sent", 32'(delivered), 32'd0);
        crd_pulses(4);
        idle(4);
        chk("ovf_delivered_4", 32'(delivered), 32'd4);
        chk("ovf_q_drained", 32'(exp_q.size()), 32'd0);
        chk("ovf_still_set", 32'(o_sb_rx_overflow), 32'd1);

        do_reset();
        chk("rst2_ovf_clr", 32'(o_sb_rx_overflow), 32'd0);
        chk("rst2_cnt", 32'(dut.crd_cnt_q), 32'd4);

        // Full FIFO with one credit: push in the same cycle as the pop.
        for (int i = 1; i <= 4; i++) push_word(32'h1F0 + 32'(i), 1'b1);
        idle(4);
        chk("full_cnt0", 32'(dut.crd_cnt_q), 32'd0);
        for (int i = 1; i <= 4; i++) push_word(32'h200 + 32'(i), 1'b1);
        chk("full_not_empty", 32'(o_fifo_empty), 32'd0);
        crd_pulses(1);
        push_word(32'h207, 1'b1);
        chk("full_push_pop_no_ovf", 32'(o_sb_rx_overflow), 32'd0);
        idle(1);
        crd_pulses(4);
        idle(4);
        chk("full_q_drained", 32'(exp_q.size()), 32'd0);
        chk("full_no_ovf_end", 32'(o_sb_rx_overflow), 32'd0);

        // Credit counter ceiling.
        crd_pulses(8);
        chk("crd_max_cnt", 32'(dut.crd_cnt_q), 32'd8);
        chk("crd_max_no_err", 32'(o_crd_err), 32'd0);
        crd_pulses(1);
        chk("crd_err_set", 32'(o_crd_err), 32'd1);
        chk("crd_sat_cnt", 32'(dut.crd_cnt_q), 32'd8);
        idle(2);
        chk("crd_err_sticky", 32'(o_crd_err), 32'd1);
        do_reset();
        chk("rst3_err_clr", 32'(o_crd_err), 32'd0);

        // Simultaneous pop and credit return at cnt=3.
        push_word(32'h301, 1'b1);
        idle(3);
        chk("popcrd_pre_cnt", 32'(dut.crd_cnt_q), 32'd3);
        push_word(32'h302, 1'b1);
        crd = 1'b1;
        step();
        crd = 1'b0;
        chk("popcrd_valid", 32'(o_pl_cfg_valid), 32'd1);
        chk("popcrd_cnt", 32'(dut.crd_cnt_q), 32'd3);

        // Reset with three words buffered discards them.
        for (int i = 1; i <= 3; i++) push_word(32'h310 + 32'(i), 1'b1);
        idle(4);
        chk("rstbuf_cnt0", 32'(dut.crd_cnt_q), 32'd0);
        for (int i = 1; i <= 3; i++) push_word(32'h320 + 32'(i), 1'b0);
        idle(1);
        chk("rstbuf_not_empty", 32'(o_fifo_empty), 32'd0);
        do_reset();
        chk("rstbuf_valid", 32'(o_pl_cfg_valid), 32'd0);
        chk("rstbuf_cfg", o_pl_cfg, 32'd0);
        chk("rstbuf_empty", 32'(o_fifo_empty), 32'd1);
        chk("rstbuf_cnt", 32'(dut.crd_cnt_q), 32'd4);
        delivered = 0;
        idle(6);
        chk("rstbuf_no_output", 32'(delivered), 32'd0);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
